// File: rtl/pipelined_adder_sub_if.sv
// Stream bundle for the pipelined adder/subtractor: operand beat in, result beat out.
// The slave modport is the adder's side; the master modport is the producer/consumer side.
interface pipelined_adder_sub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;

   modport master (
      output in_valid, in1, in2, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, overflow
   );

   modport slave (
      input  in_valid, in1, in2, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, overflow
   );
endinterface

// File: rtl/pipelined_adder_sub.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks of WIDTH/STAGES bits, one
// chunk rippled per stage, with per-stage valid bits and elastic valid/ready flow.
module pipelined_adder_sub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pipelined_adder_sub_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] cy_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic              ovf_q;

   logic [STAGES-1:0] load_w;
   logic [STAGES-1:0] src_vld;
   logic [STAGES-1:0] src_cy;
   logic [WIDTH-1:0]  src_a [STAGES];
   logic [WIDTH-1:0]  src_b [STAGES];
   logic [WIDTH-1:0]  src_s [STAGES];

   logic [STAGES-1:0] cy_d;
   logic [WIDTH-1:0]  s_d [STAGES];
   logic              ovf_d;
   logic              full_chain;
   logic [CHUNK:0]    chunk_tot;

   function automatic logic [CHUNK:0] add_chunk(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             c,
                                                input int               k);
      return {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c};
   endfunction

   // A stage may load if any stage at or downstream of it is empty, or the output drains.
   always_comb begin
      load_w     = '0;
      full_chain = 1'b1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         full_chain = full_chain & vld_q[k];
         load_w[k]  = bus.out_ready | ~full_chain;
      end
   end

   always_comb begin
      src_vld[0] = bus.in_valid;
      src_cy[0]  = bus.c_in ^ bus.sub;
      src_a[0]   = bus.in1;
      src_b[0]   = bus.in2 ^ {WIDTH{bus.sub}};
      src_s[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_vld[k] = vld_q[k-1];
         src_cy[k]  = cy_q[k-1];
         src_a[k]   = a_q[k-1];
         src_b[k]   = b_q[k-1];
         src_s[k]   = s_q[k-1];
      end
   end

   always_comb begin
      chunk_tot = '0;
      cy_d      = '0;
      for (int k = 0; k < STAGES; k++) begin
         chunk_tot                = add_chunk(src_a[k], src_b[k], src_cy[k], k);
         s_d[k]                   = src_s[k];
         s_d[k][k*CHUNK +: CHUNK] = chunk_tot[CHUNK-1:0];
         cy_d[k]                  = chunk_tot[CHUNK];
      end
      // Carry into the MSB is recovered from the MSB's own sum bit.
      ovf_d = cy_d[STAGES-1] ^ src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
              ^ s_d[STAGES-1][WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         cy_q  <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load_w[k]) begin
               vld_q[k] <= src_vld[k];
            end
            // Data only moves with a real beat, so the outputs keep the last result on bubbles.
            if (load_w[k] && src_vld[k]) begin
               a_q[k]  <= src_a[k];
               b_q[k]  <= src_b[k];
               s_q[k]  <= s_d[k];
               cy_q[k] <= cy_d[k];
            end
         end
         if (load_w[STAGES-1] && src_vld[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign bus.in_ready  = load_w[0];
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.sum       = s_q[STAGES-1];
   assign bus.c_out     = cy_q[STAGES-1];
   assign bus.overflow  = ovf_q;
endmodule
